// File: rtl/ysyx_23060229_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes,
// FSM state encoding and byte-mask base patterns.
package ysyx_23060229_lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR      = 2'd2,
    S_RESP    = 2'd3
  } lsu_state_e;

  // Byte-lane mask before shifting into position
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_23060229_lsu_align.sv
// Combinational datapath of the LSU.
//   addr_lo_i  : byte offset within the word
//   funct3_i   : RV32 funct3 of the access
//   wen_i      : 1 = store, 0 = load
//   wdata_i    : right-aligned store data
//   rdata_i    : raw memory read word
//   wdata_o    : lane-shifted store data
//   wmask_o    : byte-lane mask (upper nibble always 0)
//   ldata_o    : extracted and extended load data
//   err_o      : illegal funct3 or misaligned address
module ysyx_23060229_lsu_align
  import ysyx_23060229_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [7:0]  wmask_o,
  output logic [31:0] ldata_o,
  output logic        err_o
);

  logic [31:0] sh;
  logic [3:0]  base;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    sh = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      LB:      ldata_o = {{24{sh[7]}}, sh[7:0]};
      LH:      ldata_o = {{16{sh[15]}}, sh[15:0]};
      LBU:     ldata_o = {24'b0, sh[7:0]};
      LHU:     ldata_o = {16'b0, sh[15:0]};
      default: ldata_o = sh;
    endcase
  end

  always_comb begin
    case (funct3_i[1:0])
      2'b00:   base = MASK_B;
      2'b01:   base = MASK_H;
      default: base = MASK_W;
    endcase
    wmask_o = {4'b0000, base << addr_lo_i};
    wdata_o = wdata_i << {addr_lo_i, 3'b000};
  end

  always_comb begin
    if (wen_i) illegal = !(funct3_i inside {SB, SH, SW});
    else       illegal = !(funct3_i inside {LB, LH, LW, LBU, LHU});
    misaligned = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0])
              || ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));
    err_o = illegal || misaligned;
  end

endmodule

// File: rtl/ysyx_23060229_lsu.sv
// Load/store unit in front of the NPC data memory.
//   clk, rst             : clock, asynchronous active-low reset
//   req_*                : one request at a time, valid/ready handshake
//   resp_*               : single response with extended data and error flag
//   mem_ren/raddr/rdata  : word read port, rdata sampled after LAT cycles
//   mem_wen/waddr/wdata/wmask : word write port, one-cycle write strobe
module ysyx_23060229_lsu
  import ysyx_23060229_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LAT        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wmask
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  lsu_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wen_q, wen_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  idle;
  logic [1:0]            al_lo;
  logic [2:0]            al_f3;
  logic                  al_wen;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [7:0]            al_wmask;
  logic [DATA_WIDTH-1:0] al_ldata;
  logic                  al_err;
  logic [ADDR_WIDTH-1:0] word_addr;

  // The legality check must see the incoming request while idle; every
  // other use of the datapath works from the latched copy.
  assign idle   = (state_q == S_IDLE);
  assign al_lo  = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_f3  = idle ? req_funct3    : f3_q;
  assign al_wen = idle ? req_wen       : wen_q;

  ysyx_23060229_lsu_align u_align (
    .addr_lo_i (al_lo),
    .funct3_i  (al_f3),
    .wen_i     (al_wen),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .wdata_o   (al_wdata),
    .wmask_o   (al_wmask),
    .ldata_o   (al_ldata),
    .err_o     (al_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = al_err;
          if (al_err)       state_d = S_RESP;
          else if (req_wen) state_d = S_WR;
          else begin
            state_d = S_RD_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          rdata_d = al_ldata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign word_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  assign req_ready  = idle;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  assign mem_ren    = (state_q == S_RD_WAIT);
  assign mem_raddr  = mem_ren ? word_addr : '0;
  assign mem_wen    = (state_q == S_WR);
  assign mem_waddr  = mem_wen ? word_addr : '0;
  assign mem_wdata  = mem_wen ? al_wdata  : '0;
  assign mem_wmask  = mem_wen ? al_wmask  : '0;

endmodule

// File: tb/tb_ysyx_23060229_lsu.sv
module tb_ysyx_23060229_lsu;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  ysyx_23060229_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        is_ld;
    logic        is_st;
    logic [31:0] raddr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    int unsigned lat;
  } exp_t;

  logic [31:0] tb_mem  [256];
  logic [31:0] ref_mem [256];
  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          quiet = 1'b0;
  int unsigned rr_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed view of memory, sizes and extension from the ISA rules.
  function automatic exp_t model(input logic wen, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int unsigned size, off, idx;
    logic        legal;
    logic [31:0] v;
    e = '{default: 0};
    off  = addr % 4;
    idx  = (addr / 4) % 256;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal || (addr % size) != 0) begin
      e.err = 1'b1;
      return e;
    end
    if (wen) begin
      e.is_st = 1'b1;
      e.lat   = 1;
      e.waddr = addr - off;
      e.wdata = wdata << (8 * off);
      for (int i = 0; i < int'(size); i++) begin
        ref_mem[idx][8*(int'(off)+i) +: 8] = wdata[8*i +: 8];
        e.wmask[int'(off)+i] = 1'b1;
      end
    end else begin
      e.is_ld = 1'b1;
      e.lat   = LAT;
      e.raddr = addr - off;
      v = '0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = ref_mem[idx][8*(int'(off)+i) +: 8];
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int i = int'(size); i < 4; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
    end
    return e;
  endfunction

  // Memory behind the DUT: combinational read, masked write at posedge.
  assign mem_rdata = tb_mem[mem_raddr[9:2]];

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[0]  = 32'h80112233;
    ref_mem[0] = 32'h80112233;
    forever begin
      @(posedge clk);
      if (mem_wen)
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) tb_mem[mem_waddr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: checks memory-side activity against the head of the scoreboard
  // and pops it when the response handshake is seen.
  initial begin
    int unsigned ren_cnt, wen_cnt;
    exp_t e;
    ren_cnt = 0;
    wen_cnt = 0;
    forever begin
      @(negedge clk);
      if (!quiet && rst) begin
        if (mem_ren) begin
          ren_cnt++;
          if (sbq.size() == 0) chk("ren_while_idle", {31'b0, mem_ren}, 32'd0);
          else                 chk("mem_raddr", mem_raddr, sbq[0].raddr);
        end
        if (mem_wen) begin
          wen_cnt++;
          if (sbq.size() == 0) chk("wen_while_idle", {31'b0, mem_wen}, 32'd0);
          else begin
            chk("mem_waddr", mem_waddr, sbq[0].waddr);
            chk("mem_wdata", mem_wdata, sbq[0].wdata);
            chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, sbq[0].wmask});
          end
        end
        if (resp_valid && resp_ready) begin
          if (sbq.size() == 0) chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
          else begin
            e = sbq.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            chk("ren_cycles", ren_cnt, e.is_ld ? LAT : 0);
            chk("wen_cycles", wen_cnt, e.is_st ? 1 : 0);
          end
          ren_cnt = 0;
          wen_cnt = 0;
        end
      end
    end
  end

  task automatic scramble();
    req_wen    = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic issue(input logic wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
      return;
    end
    e = model(wen, f3, addr, wdata);
    sbq.push_back(e);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    scramble();
    chk("busy_not_ready", {31'b0, req_ready}, 32'd0);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("resp_latency", n, e.lat);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    scramble();
    #12;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_mem_ren", {31'b0, mem_ren}, 32'd0);
    chk("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_mem_wmask", {24'b0, mem_wmask}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Sign/zero extension of the top byte lane
    issue(1'b0, 3'b000, 32'h80000003, 32'h0);
    issue(1'b0, 3'b100, 32'h80000003, 32'h0);
    // Upper-half store, then read the whole word back
    issue(1'b1, 3'b001, 32'h80000102, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h80000100, 32'h0);
    // Misaligned word load and illegal store funct3
    issue(1'b0, 3'b010, 32'h80000002, 32'h0);
    issue(1'b1, 3'b011, 32'h80000010, 32'h12345678);
    issue(1'b0, 3'b110, 32'h80000010, 32'h0);
    issue(1'b0, 3'b101, 32'h80000021, 32'h0);

    // Response backpressure
    rr_mode = 2;
    issue(1'b0, 3'b010, 32'h80000010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("bp_resp_rdata", resp_rdata, sbq.size() > 0 ? sbq[0].rdata : 32'hxxxxxxxx);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rr_mode = 0;

    // Reset while the store is in its write cycle
    begin
      int unsigned n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      quiet      = 1'b1;
      req_valid  = 1'b1;
      req_wen    = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h80000040;
      req_wdata  = ~ref_mem[16];
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("abort_wen_before", {31'b0, mem_wen}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_wen_drop", {31'b0, mem_wen}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_mem_unchanged", tb_mem[16], ref_mem[16]);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
      end
      quiet = 1'b0;
    end

    // Back-to-back store then load of the same word
    issue(1'b1, 3'b010, 32'h80000080, 32'hCAFEF00D);
    issue(1'b0, 3'b010, 32'h80000080, 32'h0);
    issue(1'b0, 3'b001, 32'h80000082, 32'h0);

    // Randomized traffic with random response backpressure
    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) == 1) ? (32'h80000000 | 32'($urandom_range(0, 1023))) : $urandom;
      issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
    end
    rr_mode = 0;

    for (int i = 0; i < 50 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    for (int i = 0; i < 256; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
